// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST run controller.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    CAPTURE,
    DONE
  } state_t;

  localparam int DEF_SIG_WIDTH     = 4;
  localparam int DEF_PATTERN_COUNT = 7;

endpackage

// File: rtl/bist_pattern_counter.sv
// Pattern counter: counts enabled cycles and flags the last one of a run.
module bist_pattern_counter
  import bist_pkg::*;
#(
  parameter int PATTERN_COUNT = DEF_PATTERN_COUNT,
  parameter int CNT_WIDTH     = $clog2(PATTERN_COUNT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(PATTERN_COUNT - 1);

  logic [CNT_WIDTH-1:0] count;

  // Up-count while enabled; a synchronous clear restarts the run at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

  // The run leaves RUN on the edge where this is high, so the count never wraps.
  assign terminal = (count == LAST);

endmodule

// File: rtl/bist_controller.sv
// BIST run controller: clears the MISR, runs the pattern generator for a
// fixed number of cycles, then captures and checks the signature.
module bist_controller
  import bist_pkg::*;
#(
  parameter int SIG_WIDTH     = DEF_SIG_WIDTH,
  parameter int PATTERN_COUNT = DEF_PATTERN_COUNT,
  parameter int CNT_WIDTH     = $clog2(PATTERN_COUNT + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SIG_WIDTH-1:0] golden,
  input  logic [SIG_WIDTH-1:0] misrSig,
  output logic                 misrClear,
  output logic                 tpgEnable,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature
);

  state_t               state;
  logic [SIG_WIDTH-1:0] golden_q;
  logic                 cnt_clear;
  logic                 cnt_enable;
  logic                 cnt_terminal;

  assign cnt_clear  = (state == IDLE) && start;
  assign cnt_enable = (state == RUN);

  bist_pattern_counter #(
    .PATTERN_COUNT (PATTERN_COUNT),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_terminal)
  );

  // Run sequencing; every output is registered alongside the state it belongs to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      golden_q  <= '0;
      misrClear <= 1'b0;
      tpgEnable <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      misrClear <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            golden_q  <= golden;
            pass      <= 1'b0;
            signature <= '0;
            misrClear <= 1'b1;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= RUN;
            tpgEnable <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            tpgEnable <= 1'b0;
          end else if (cnt_terminal) begin
            state     <= CAPTURE;
            tpgEnable <= 1'b0;
          end
        end
        CAPTURE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= DONE;
            signature <= misrSig;
            pass      <= (misrSig == golden_q);
            done      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          tpgEnable <= 1'b0;
        end
      endcase
    end
  end

endmodule
